serial_multiplier_param: RTL and testbench
==========================================

SERIAL_MULTIPLIER_PARAM -- requirements
Module: serial_multiplier_param

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  start request; sampled only while idle.
REQ-005 sgn  input  1  mode, sampled with en: 0 = unsigned operands, 1 = two's-complement operands.
REQ-006 A  input  WIDTH  multiplicand, sampled on the accepting edge.
REQ-007 B  input  WIDTH  multiplier, sampled on the accepting edge.
REQ-008 busy  output  1  high while a multiplication is in progress (CALC or DONE).
REQ-009 valid  output  1  one-cycle pulse marking a new result on S.
REQ-010 S  output  2*WIDTH  product, unsigned or two's-complement per captured sgn.

Function
REQ-011 FSM states SHALL be IDLE, CALC and DONE.
REQ-012 IDLE -> CALC on an edge with en=1; A, B and sgn SHALL be captured on that edge (the accepting edge k).
REQ-013 On capture, sgn=1 SHALL store |A| and |B| as WIDTH-bit unsigned magnitudes plus neg = A[MSB] xor B[MSB]; sgn=0 SHALL store A, B unchanged with neg = 0.
REQ-014 Each CALC cycle SHALL process one multiplier bit, LSB first: add the shifted multiplicand to a 2*WIDTH accumulator if the bit is 1, then shift the multiplier right and the multiplicand left by one.
REQ-015 CALC -> DONE when the shifted multiplier is zero after the update (zero-skip) or WIDTH bits have been processed; CALC SHALL last n = max(1, position of MSB set in |B| + 1) cycles.
REQ-016 In DONE, S SHALL be loaded with the accumulator (two's-complement negated if neg=1), valid SHALL be asserted for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-017 Latency: valid SHALL be high in the cycle following edge k+n+1; the next en is accepted no earlier than edge k+n+2.
REQ-018 en while busy=1 SHALL be ignored; inputs are not recaptured and the running operation is unaffected.
REQ-019 S SHALL hold its last value between valid pulses; A and B changes after capture SHALL NOT affect the result.
REQ-020 Signed -2^(WIDTH-1) operands SHALL be handled exactly (magnitude 2^(WIDTH-1) fits WIDTH unsigned bits); the product always fits 2*WIDTH bits with no overflow.
REQ-021 A = 0 or B = 0 SHALL give S = 0 with no negative zero (neg ignored when the accumulator is 0).

Reset
REQ-022 rst_n=0 on an edge SHALL force IDLE, S=0, valid=0, busy=0, and clear the accumulator, operand registers and bit counter.
REQ-023 Reset mid-operation SHALL abort with no valid pulse; the first en after release starts a fresh operation.
REQ-024 en sampled on an edge where rst_n=0 SHALL be ignored.

Structure
REQ-025 Package serial_mult_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the WIDTH-bounds check constants.
REQ-026 Module SHALL be monolithic; no sub-module is required (the abs/negate logic is an inline function).

Verification (WIDTH=8)
REQ-027 Unsigned 255 x 255 -> S = 0xFE01; valid exactly one cycle, n = 8 CALC cycles.
REQ-028 Signed -128 x -128 -> S = 0x4000; signed -3 x 5 -> S = 0xFFF1 with n = 3.
REQ-029 Unsigned 0xAB x 0 -> S = 0x0000 after n = 1; signed -7 x 0 -> S = 0x0000.
REQ-030 en re-pulsed with A=1, B=1 during an operation of 12 x 10 -> single valid, S = 120, busy held throughout.
REQ-031 rst_n low two cycles after accepting 200 x 200 -> no valid, S = 0; the next op 3 x 4 -> S = 12.
REQ-032 Random regression: 1000 ops, mixed sgn, checked against a golden product and the REQ-015 latency formula.

Source files
------------

// File: rtl/serial_mult_pkg.sv
// Shared definitions for the shift-and-add serial multiplier.
package serial_mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mult_state_e;

  localparam int unsigned MinWidth = 2;
  localparam int unsigned MaxWidth = 32;

endpackage

// File: rtl/serial_multiplier_param.sv
// Serial shift-and-add multiplier: one multiplier bit per cycle, LSB first, with zero-skip
// early exit and sign-magnitude handling of two's-complement operands.
module serial_multiplier_param
  import serial_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] S
);

  if (WIDTH < MinWidth || WIDTH > MaxWidth) begin : g_width_check
    $error("serial_multiplier_param: WIDTH out of range");
  end

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  // -2^(WIDTH-1) maps onto itself, which read as unsigned is the correct magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  mult_state_e        state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] s_q, s_d;
  logic               valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    s_d     = s_q;
    valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          mcand_d = {{WIDTH{1'b0}}, (sgn ? magnitude(A) : A)};
          mplr_d  = sgn ? magnitude(B) : B;
          neg_d   = sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (mplr_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + 1'b1;
        if (mplr_d == '0 || cnt_q == LastBit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // A zero product is never negated, so no negative zero can appear.
        s_d     = (neg_q && acc_q != '0) ? (~acc_q + 1'b1) : acc_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = valid_q;
  assign S     = s_q;

endmodule

// File: tb/tb_serial_multiplier_param.sv
// Scoreboard bench for serial_multiplier_param (WIDTH=8): directed vectors plus a random run.
module tb_serial_multiplier_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sgn;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        valid;
  logic [15:0] S;

  always #5 clk = ~clk;

  serial_multiplier_param #(
    .WIDTH(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .sgn  (sgn),
    .A    (A),
    .B    (B),
    .busy (busy),
    .valid(valid),
    .S    (S)
  );

  typedef struct {
    logic [15:0] s;
    int unsigned at;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned pcnt  = 0;
  logic [15:0] s_hold = 16'h0;

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per valid pulse; between pulses S must hold.
  always @(negedge clk) begin
    exp_t e;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got valid with S=0x%0h, expected no valid", S);
      end else begin
        e = sb.pop_front();
        check({e.name, "_S"}, {16'h0, S}, {16'h0, e.s});
        check({e.name, "_latency"}, pcnt, e.at);
        s_hold = e.s;
      end
    end else if (rst_n === 1'b0) begin
      s_hold = 16'h0;
    end else begin
      check("S_hold", {16'h0, S}, {16'h0, s_hold});
    end
  end

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic issue(input string name, input logic s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input int unsigned n);
    exp_t e;
    sgn = s;
    A   = a;
    B   = b;
    en  = 1'b1;
    e.s = exp;
    e.at = pcnt + n + 2;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    en  = 1'b0;
    A   = 8'($urandom);
    B   = 8'($urandom);
    sgn = 1'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, k);
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input int unsigned n);
    issue(name, s, a, b, exp, n);
    wait_idle(name);
  endtask

  initial begin
    logic [7:0]         ra, rb, mag;
    logic               rs;
    logic signed [15:0] prod;
    int unsigned        rn;

    rst_n = 1'b0;
    en    = 1'b1;
    sgn   = 1'b0;
    A     = 8'd5;
    B     = 8'd5;
    repeat (3) @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_S", {16'h0, S}, 32'h0);

    run_op("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8);
    run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000, 8);
    run_op("s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1, 3);
    run_op("uABx0", 1'b0, 8'hAB, 8'h00, 16'h0000, 1);
    run_op("s_m7x0", 1'b1, 8'hF9, 8'h00, 16'h0000, 1);
    run_op("u0x15", 1'b0, 8'h00, 8'h0F, 16'h0000, 4);
    run_op("s_7xm1", 1'b1, 8'h07, 8'hFF, 16'hFFF9, 1);
    run_op("s_127xm128", 1'b1, 8'h7F, 8'h80, 16'hC080, 8);
    run_op("s_m128x127", 1'b1, 8'h80, 8'h7F, 16'hC080, 7);
    run_op("u128x2", 1'b0, 8'h80, 8'h02, 16'h0100, 2);
    run_op("s_m128x1", 1'b1, 8'h80, 8'h01, 16'hFF80, 1);

    // en re-pulsed with 1 x 1 while 12 x 10 (n=4) is running.
    sgn = 1'b0;
    A   = 8'd12;
    B   = 8'd10;
    en  = 1'b1;
    begin
      exp_t e;
      e.s = 16'd120;
      e.at = pcnt + 4 + 2;
      e.name = "busy_ignore";
      sb.push_back(e);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      en = (i <= 3);
      A  = 8'd1;
      B  = 8'd1;
      check("busy_held", {31'h0, busy}, 32'h1);
    end
    @(negedge clk);
    check("busy_released", {31'h0, busy}, 32'h0);

    // Reset two cycles after accepting 200 x 200: aborted, no valid.
    sgn = 1'b0;
    A   = 8'd200;
    B   = 8'd200;
    en  = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (2) @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_S", {16'h0, S}, 32'h0);
    repeat (12) @(negedge clk);
    check("abort_no_valid_queue", sb.size(), 32'h0);
    run_op("u3x4", 1'b0, 8'd3, 8'd4, 16'd12, 3);

    for (int t = 0; t < 1000; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (rs) begin
        prod = $signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb});
        mag  = rb[7] ? 8'(-rb) : rb;
      end else begin
        prod = $signed({8'h0, ra} * {8'h0, rb});
        mag  = rb;
      end
      rn = 1;
      for (int i = 0; i < 8; i++) begin
        if (mag[i]) rn = i + 1;
      end
      run_op("rand", rs, ra, rb, prod, rn);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
